// File: rtl/fetch_pc_stage_if.sv
// Fetch-stage bus: hazard/predictor/IMEM inputs and the PC, IF/ID and counter outputs.
interface fetch_pc_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CNT_W = 16
);

  // Into the fetch stage
  logic             stall_i;
  logic             flush_i;
  logic [XLEN-1:0]  nxt_pc_i;
  logic [31:0]      imem_rdata_i;

  // Out of the fetch stage
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  pc_four_o;
  logic [IDX_W-1:0] pc_idx_o;
  logic [4:0]       opcode_o;
  logic             id_valid_o;
  logic [31:0]      id_instr_o;
  logic [XLEN-1:0]  id_pc_o;
  logic [XLEN-1:0]  id_pc_four_o;
  logic             ex_kill_o;
  logic [CNT_W-1:0] fetch_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Environment side: hazard unit, predictor and IMEM
  modport master (
    output stall_i, flush_i, nxt_pc_i, imem_rdata_i,
    input  pc_o, pc_four_o, pc_idx_o, opcode_o,
    input  id_valid_o, id_instr_o, id_pc_o, id_pc_four_o,
    input  ex_kill_o, fetch_cnt_o, flush_cnt_o
  );

  // Fetch stage side
  modport slave (
    input  stall_i, flush_i, nxt_pc_i, imem_rdata_i,
    output pc_o, pc_four_o, pc_idx_o, opcode_o,
    output id_valid_o, id_instr_o, id_pc_o, id_pc_four_o,
    output ex_kill_o, fetch_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/fetch_pc_stage.sv
// Fetch PC register plus IF/ID pipeline register. Loads the predictor's next PC
// each cycle, squashes IF/ID and pulses ex_kill_o on a redirect, and keeps
// saturating fetch/redirect counters.
module fetch_pc_stage #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      IDX_W    = 8,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  fetch_pc_stage_if.slave bus
);

  localparam logic [31:0]     NOP       = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_ALN = {RESET_PC[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIR
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [XLEN-1:0]  id_pc_q, id_pc_d;
  logic [XLEN-1:0]  id_pc_four_q, id_pc_four_d;
  logic             ex_kill_q, ex_kill_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [XLEN-1:0]  pc_four;
  logic [XLEN-1:0]  nxt_pc_aln;
  logic [CNT_W-1:0] fetch_cnt_inc;
  logic [CNT_W-1:0] flush_cnt_inc;
  logic             unused_nxt_pc_lsbs;

  // Fetch address arithmetic and word alignment of the predictor target
  always_comb begin
    pc_four            = pc_q + XLEN'(4);
    nxt_pc_aln         = {bus.nxt_pc_i[XLEN-1:2], 2'b00};
    unused_nxt_pc_lsbs = ^bus.nxt_pc_i[1:0];
  end

  // Saturating increments: hold at all-ones instead of wrapping
  always_comb begin
    fetch_cnt_inc = (&fetch_cnt_q) ? fetch_cnt_q : fetch_cnt_q + CNT_W'(1);
    flush_cnt_inc = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
  end

  // Next-state and next-register values; REDIR fetches exactly like RUN and
  // only exists so the redirect cycle is visible as a distinct state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc_four_d = id_pc_four_q;
    ex_kill_d    = 1'b0;
    fetch_cnt_d  = fetch_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    unique case (state_q)
      BOOT: begin
        // Predictor output not yet meaningful: hold PC, keep IF/ID empty
        state_d = RUN;
      end
      RUN, REDIR: begin
        if (bus.flush_i) begin
          state_d     = REDIR;
          pc_d        = nxt_pc_aln;
          id_valid_d  = 1'b0;
          id_instr_d  = NOP;
          ex_kill_d   = 1'b1;
          flush_cnt_d = flush_cnt_inc;
        end else if (bus.stall_i) begin
          state_d = RUN;
        end else begin
          state_d      = RUN;
          pc_d         = nxt_pc_aln;
          id_valid_d   = 1'b1;
          id_instr_d   = bus.imem_rdata_i;
          id_pc_d      = pc_q;
          id_pc_four_d = pc_four;
          fetch_cnt_d  = fetch_cnt_inc;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and pipeline registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT;
      pc_q         <= RESET_ALN;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP;
      id_pc_q      <= '0;
      id_pc_four_q <= '0;
      ex_kill_q    <= 1'b0;
      fetch_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc_four_q <= id_pc_four_d;
      ex_kill_q    <= ex_kill_d;
      fetch_cnt_q  <= fetch_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Output drive: predictor stage-0 taps are combinational off the PC and IMEM
  always_comb begin
    bus.pc_o         = pc_q;
    bus.pc_four_o    = pc_four;
    bus.pc_idx_o     = pc_q[IDX_W+1:2];
    bus.opcode_o     = bus.imem_rdata_i[6:2];
    bus.id_valid_o   = id_valid_q;
    bus.id_instr_o   = id_instr_q;
    bus.id_pc_o      = id_pc_q;
    bus.id_pc_four_o = id_pc_four_q;
    bus.ex_kill_o    = ex_kill_q;
    bus.fetch_cnt_o  = fetch_cnt_q;
    bus.flush_cnt_o  = flush_cnt_q;
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Randomized bench for fetch_pc_stage with an in-bench reference model.
module tb_fetch_pc_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst_n;

  logic        st, fl;
  logic [31:0] npc, ir;

  int unsigned pass_cnt  = 0;
  int unsigned check_cnt = 0;

  // Reference model: architectural view only
  logic             m_booted;
  logic [31:0]      m_pc;
  logic             m_idv;
  logic [31:0]      m_instr, m_idpc, m_idpc4;
  logic             m_kill;
  logic [CNT_W-1:0] m_fc, m_flc;
  logic [CNT_W-1:0] saved_fc;

  fetch_pc_stage_if #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  assign bus.stall_i      = st;
  assign bus.flush_i      = fl;
  assign bus.nxt_pc_i     = npc;
  assign bus.imem_rdata_i = ir;

  fetch_pc_stage #(.XLEN(XLEN), .IDX_W(IDX_W), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act !== exp)
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic model_reset();
    m_booted = 1'b0;
    m_pc     = 32'h0;
    m_idv    = 1'b0;
    m_instr  = NOP;
    m_idpc   = 32'h0;
    m_idpc4  = 32'h0;
    m_kill   = 1'b0;
    m_fc     = '0;
    m_flc    = '0;
  endtask

  // One clock edge of the fetch stage, as described by its rules
  task automatic model_step();
    if (!m_booted) begin
      m_booted = 1'b1;
      m_kill   = 1'b0;
    end else if (fl) begin
      m_pc    = npc & 32'hFFFF_FFFC;
      m_idv   = 1'b0;
      m_instr = NOP;
      m_kill  = 1'b1;
      if (m_flc != '1) m_flc = m_flc + 1'b1;
    end else if (st) begin
      m_kill = 1'b0;
    end else begin
      m_idv   = 1'b1;
      m_instr = ir;
      m_idpc  = m_pc;
      m_idpc4 = m_pc + 32'd4;
      m_pc    = npc & 32'hFFFF_FFFC;
      m_kill  = 1'b0;
      if (m_fc != '1) m_fc = m_fc + 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_p4;
    exp_p4 = m_pc + 32'd4;
    chk("pc",         bus.pc_o,         m_pc);
    chk("pc_four",    bus.pc_four_o,    exp_p4);
    chk("pc_idx",     bus.pc_idx_o,     m_pc[IDX_W+1:2]);
    chk("opcode",     bus.opcode_o,     ir[6:2]);
    chk("id_valid",   bus.id_valid_o,   m_idv);
    chk("id_instr",   bus.id_instr_o,   m_instr);
    chk("id_pc",      bus.id_pc_o,      m_idpc);
    chk("id_pc_four", bus.id_pc_four_o, m_idpc4);
    chk("ex_kill",    bus.ex_kill_o,    m_kill);
    chk("fetch_cnt",  bus.fetch_cnt_o,  m_fc);
    chk("flush_cnt",  bus.flush_cnt_o,  m_flc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    st = 1'b0; fl = 1'b0; npc = 32'h0; ir = $urandom;
    model_reset();
    #12;
    compare_all();
    chk("reset_pc_lit", bus.pc_o, 32'h0);
    chk("reset_instr_lit", bus.id_instr_o, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from reset: BOOT edge holds PC, then +4 per edge
    npc = m_pc + 32'd4; ir = $urandom; tick();
    chk("boot_pc_lit", bus.pc_o, 32'h0);
    chk("boot_valid_lit", bus.id_valid_o, 1'b0);
    npc = m_pc + 32'd4; ir = $urandom; tick();
    chk("run1_pc_lit", bus.pc_o, 32'h4);
    chk("run1_valid_lit", bus.id_valid_o, 1'b1);
    chk("run1_idpc_lit", bus.id_pc_o, 32'h0);
    chk("run1_fcnt_lit", bus.fetch_cnt_o, 8'd1);
    npc = m_pc + 32'd4; ir = $urandom; tick();
    chk("run2_pc_lit", bus.pc_o, 32'h8);
    npc = m_pc + 32'd4; ir = $urandom; tick();
    chk("run3_pc_lit", bus.pc_o, 32'hC);

    // Redirect at 0x20
    for (int unsigned i = 0; i < 16 && m_pc != 32'h20; i++) begin
      npc = m_pc + 32'd4; ir = $urandom; tick();
    end
    fl = 1'b1; npc = 32'h80; ir = $urandom; tick();
    chk("flush_pc_lit", bus.pc_o, 32'h80);
    chk("flush_valid_lit", bus.id_valid_o, 1'b0);
    chk("flush_kill_lit", bus.ex_kill_o, 1'b1);
    chk("flush_cnt_lit", bus.flush_cnt_o, 8'd1);
    fl = 1'b0; npc = 32'h84; ir = $urandom; tick();
    chk("kill_drop_lit", bus.ex_kill_o, 1'b0);

    // Stall at 0x40
    npc = 32'h40; ir = $urandom; tick();
    saved_fc = m_fc;
    st = 1'b1; npc = 32'h999; ir = $urandom;
    for (int unsigned i = 0; i < 3; i++) tick();
    chk("stall_pc_lit", bus.pc_o, 32'h40);
    chk("stall_fcnt_held", bus.fetch_cnt_o, saved_fc);
    st = 1'b0; npc = 32'h44; tick();
    chk("unstall_pc_lit", bus.pc_o, 32'h44);

    // Stall and flush together: flush wins
    st = 1'b1; fl = 1'b1; npc = 32'h100; tick();
    chk("sf_pc_lit", bus.pc_o, 32'h100);
    chk("sf_valid_lit", bus.id_valid_o, 1'b0);
    chk("sf_kill_lit", bus.ex_kill_o, 1'b1);

    // Back-to-back flush from REDIR
    st = 1'b0; fl = 1'b1; npc = 32'h200; tick();
    chk("b2b_kill_lit", bus.ex_kill_o, 1'b1);
    chk("b2b_fcnt_lit", bus.flush_cnt_o, 8'd3);
    chk("b2b_valid_lit", bus.id_valid_o, 1'b0);
    fl = 1'b0; npc = 32'h204; tick();
    chk("b2b_kill_drop_lit", bus.ex_kill_o, 1'b0);

    // Top of address space, low target bits dropped
    fl = 1'b1; npc = 32'hFFFF_FFFF; tick();
    chk("wrap_pc_lit", bus.pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4_lit", bus.pc_four_o, 32'h0);
    fl = 1'b0; st = 1'b1; tick();
    fl = 1'b0; st = 1'b0; npc = 32'h300; tick();
    chk("wrap_idpc4_lit", bus.id_pc_four_o, 32'h0);

    // Random traffic with one asynchronous reset in the middle
    for (int unsigned c = 0; c < 2000; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      npc = $urandom;
      ir  = $urandom;
      if (c == 1000) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pc_lit", bus.pc_o, 32'h0);
        chk("async_rst_valid_lit", bus.id_valid_o, 1'b0);
        chk("async_rst_fcnt_lit", bus.fetch_cnt_o, 8'd0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end

    // Counter saturation
    st = 1'b0; fl = 1'b0;
    for (int unsigned c = 0; c < 300; c++) begin
      npc = m_pc + 32'd4; ir = $urandom; tick();
    end
    chk("fcnt_sat_lit", bus.fetch_cnt_o, 8'hFF);
    fl = 1'b1;
    for (int unsigned c = 0; c < 300; c++) begin
      npc = $urandom; tick();
    end
    chk("flcnt_sat_lit", bus.flush_cnt_o, 8'hFF);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
